// File: rtl/posix_time_pkg.sv
// rtl/posix_time_pkg.sv - shared constants, state type and helpers for the h:m:s to POSIX encoder
//
// Purpose : time constants, field widths, FSM state enum and small arithmetic
//           helpers used by time_to_posix_time and posix_div_day.
// Ports   : none (package).

package posix_time_pkg;

  localparam int unsigned POSIX_W = 32;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;

  localparam logic [31:0] SECS_PER_DAY  = 32'd86400;
  localparam logic [31:0] SECS_PER_HOUR = 32'd3600;
  localparam logic [31:0] SECS_PER_MIN  = 32'd60;

  // 86400 needs 17 bits; the partial remainder needs one more bit for the
  // shifted-in dividend bit before the trial subtraction.
  localparam int unsigned DIVISOR_W = 17;
  localparam int unsigned REM_W     = 18;
  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    COMPOSE = 2'd2
  } t2p_state_t;

  // Seconds since local midnight; out-of-range fields are summed as given.
  function automatic logic [31:0] tod_seconds(input logic [HOUR_W-1:0] hour,
                                              input logic [MIN_W-1:0]  min,
                                              input logic [SEC_W-1:0]  sec);
    return 32'(hour) * SECS_PER_HOUR + 32'(min) * SECS_PER_MIN + 32'(sec);
  endfunction

  // Signed hour offset turned into a modulo-2^32 second offset.
  function automatic logic [31:0] gmt_offset(input int gmt);
    return 32'(gmt * 3600);
  endfunction

endpackage

// File: rtl/time_to_posix_time_if.sv
// rtl/time_to_posix_time_if.sv - request/response bundle of the h:m:s to POSIX encoder
//
// Purpose : groups the request fields and the result/strobe signals.
// Signals : posix_time_i [32]  current POSIX time
//           hour_i [5], min_i [6], sec_i [6]  user wall-clock time
//           set_i              request pulse
//           busy_o             request in progress (through strobe cycle)
//           user_posix_time_o [32]  computed POSIX time
//           user_posix_time_en_o    one-cycle load strobe
//           range_err_o             one-cycle reject strobe
// Modports: master (requester), slave (encoder).

interface time_to_posix_time_if;
  import posix_time_pkg::*;

  logic [POSIX_W-1:0] posix_time_i;
  logic [HOUR_W-1:0]  hour_i;
  logic [MIN_W-1:0]   min_i;
  logic [SEC_W-1:0]   sec_i;
  logic               set_i;
  logic               busy_o;
  logic [POSIX_W-1:0] user_posix_time_o;
  logic               user_posix_time_en_o;
  logic               range_err_o;

  modport master (
    output posix_time_i, hour_i, min_i, sec_i, set_i,
    input  busy_o, user_posix_time_o, user_posix_time_en_o, range_err_o
  );

  modport slave (
    input  posix_time_i, hour_i, min_i, sec_i, set_i,
    output busy_o, user_posix_time_o, user_posix_time_en_o, range_err_o
  );

endinterface

// File: rtl/posix_div_day.sv
// rtl/posix_div_day.sv - serial 32-step restoring divider by 86400
//
// Purpose : divides a 32-bit value by 86400, one quotient bit per clock, MSB first.
// Ports   : clk        in   clock
//           rst_n      in   asynchronous active-low reset
//           start      in   load dividend, clear quotient/remainder (ignored while busy)
//           dividend   in   [32] value to divide
//           busy       out  steps in progress
//           done       out  high in the cycle whose closing edge performs the last step
//           quotient   out  [32]
//           remainder  out  [18]

module posix_div_day
  import posix_time_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [POSIX_W-1:0] dividend,
  output logic               busy,
  output logic               done,
  output logic [POSIX_W-1:0] quotient,
  output logic [REM_W-1:0]   remainder
);

  localparam logic [REM_W-1:0] DIVISOR = REM_W'(SECS_PER_DAY);

  logic [POSIX_W-1:0] dividend_q;
  logic [4:0]         step_q;
  logic [REM_W-1:0]   trial;
  logic               fits;

  // Remainder is always < 86400 < 2^17, so dropping its top bit is lossless.
  assign trial = {remainder[DIVISOR_W-1:0], dividend_q[POSIX_W-1]};
  assign fits  = (trial >= DIVISOR);
  assign done  = busy && (step_q == 5'(DIV_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= '0;
      step_q     <= '0;
      busy       <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
    end else if (start && !busy) begin
      dividend_q <= dividend;
      step_q     <= '0;
      busy       <= 1'b1;
      quotient   <= '0;
      remainder  <= '0;
    end else if (busy) begin
      dividend_q <= dividend_q << 1;
      step_q     <= step_q + 5'd1;
      quotient   <= {quotient[POSIX_W-2:0], fits};
      remainder  <= fits ? (trial - DIVISOR) : trial;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/time_to_posix_time.sv
// rtl/time_to_posix_time.sv - user h:m:s to POSIX seconds encoder (keeps today's local date)
//
// Purpose : replaces the local time-of-day of posix_time_i with the user h:m:s and
//           emits the resulting POSIX time with a one-cycle load strobe.
//           Accept edge E0 -> 32 divide steps (E1..E32) -> compose at E33 ->
//           strobe in the cycle after E33; busy_o drops at E34.
// Params  : GMT  signed local offset in hours, applied as GMT*3600 mod 2^32.
// Ports   : clk_i    in  clock
//           rst_n_i  in  asynchronous active-low reset
//           bus      time_to_posix_time_if.slave (request fields, result, strobes)
// Config  : RANGE_CHECK_EN - when defined, requests with hour>23, min>59 or sec>59
//           are rejected with a range_err_o pulse; otherwise range_err_o is 0.

module time_to_posix_time
  import posix_time_pkg::*;
#(
  parameter int GMT = 3
)(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  time_to_posix_time_if.slave  bus
);

  localparam logic [POSIX_W-1:0] GMT_OFS = gmt_offset(GMT);

  t2p_state_t         state_q, state_d;
  logic [POSIX_W-1:0] local_q;
  logic [HOUR_W-1:0]  hour_q;
  logic [MIN_W-1:0]   min_q;
  logic [SEC_W-1:0]   sec_q;
  logic [POSIX_W-1:0] result_q;
  logic               en_q;
  logic               start;
  logic               fields_bad;
  logic [POSIX_W-1:0] compose_value;

  logic               div_busy;
  logic               div_done;
  logic [POSIX_W-1:0] div_quotient;
  logic [REM_W-1:0]   div_rem;

  // Only the remainder is needed to find the local day boundary.
  wire unused_div = ^{div_busy, div_quotient};

`ifdef RANGE_CHECK_EN
  logic range_err_q;
  assign fields_bad = (bus.hour_i > 5'd23) || (bus.min_i > 6'd59) || (bus.sec_i > 6'd59);
  assign bus.range_err_o = range_err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= (state_q == IDLE) && bus.set_i && fields_bad;
    end
  end
`else
  assign fields_bad      = 1'b0;
  assign bus.range_err_o = 1'b0;
`endif

  posix_div_day u_div (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .start     (start),
    .dividend  (posix_time_i_local()),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_rem)
  );

  // Local time at the accept edge; the divider loads the same value as local_q.
  function automatic logic [POSIX_W-1:0] posix_time_i_local();
    return bus.posix_time_i + GMT_OFS;
  endfunction

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.set_i && !fields_bad) begin
          start   = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = COMPOSE;
        end
      end
      COMPOSE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Local midnight (local - rem), plus the user time of day, shifted back to UTC.
  assign compose_value = (local_q - {{(POSIX_W-REM_W){1'b0}}, div_rem})
                       + tod_seconds(hour_q, min_q, sec_q) - GMT_OFS;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      local_q  <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      result_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b0;
      if (start) begin
        local_q <= posix_time_i_local();
        hour_q  <= bus.hour_i;
        min_q   <= bus.min_i;
        sec_q   <= bus.sec_i;
      end
      if (state_q == COMPOSE) begin
        result_q <= compose_value;
        en_q     <= 1'b1;
      end
    end
  end

  // The FSM is already back in IDLE during the strobe cycle, so the strobe keeps busy high.
  assign bus.busy_o               = (state_q != IDLE) || en_q;
  assign bus.user_posix_time_o    = result_q;
  assign bus.user_posix_time_en_o = en_q;

endmodule
